spi_ram_slave_param: RTL and testbench
======================================

Name: spi_ram_slave_param

Overview:
Parametrised SPI slave with an integrated single-port RAM. It decodes 2-bit-command frames sampled on the system clock and supports write-address, write-data, read-address and read-data commands. Beyond the fixed 8-bit design, it adds configurable data, address and depth, pointer auto-increment, multi-frame bursts under one SS_n assertion, and an out-of-range error flag. It is the memory-mapped SPI endpoint of the chip top.

Parameters:
DATA_WIDTH, 8, RAM word width and MISO read-out length.
ADDR_WIDTH, 8, address pointer width.
MEM_DEPTH, 256, number of RAM words; must be ≤ 2**ADDR_WIDTH.
AUTO_INC, 1, when 1 the pointer increments after each data write or read.

Ports:
clk  input  1  system clock; all SPI pins sampled on rising edge.
rst  input  1  synchronous reset, active-high.
SS_n  input  1  slave select, active-low.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first.
busy  output  1  high while state is not IDLE.
err  output  1  sticky: an address ≥ MEM_DEPTH was received.

Behaviour:
- P = max(ADDR_WIDTH, DATA_WIDTH). A frame is F = 2+P bits: cmd[1:0] then payload, MSB first. Address = payload[ADDR_WIDTH-1:0]; data = payload[DATA_WIDTH-1:0].
- Reset: state IDLE, MISO=0, busy=0, err=0, wr_ptr=0, rd_ptr=0, shift and bit counters 0. RAM contents are not reset.
- States: IDLE, CHK_CMD, RX, READ_WAIT, TX.
- IDLE: on an edge with SS_n=0, go to CHK_CMD. No bit is sampled on that edge.
- CHK_CMD: samples cmd[1] (frame bit e1), then goes to RX.
- RX: samples bits e2..eF. The command executes on edge eF using {shift, MOSI}:
  - 00: wr_ptr ← addr.
  - 01: mem[wr_ptr] ← data; if AUTO_INC, wr_ptr ← (wr_ptr == MEM_DEPTH-1) ? 0 : wr_ptr+1.
  - 10: rd_ptr ← addr.
  - 11: payload is ignored; go to READ_WAIT.
  - After 00/01/10: if SS_n is sampled low at eF, go to CHK_CMD (burst); otherwise go to IDLE.
- Address ≥ MEM_DEPTH on 00/10: err ← 1, and the pointer is unchanged.
- READ_WAIT (one cycle): at edge eF+1, tx_reg ← mem[rd_ptr], MISO ← MSB, auto-increment rd_ptr with the same wrap rule; go to TX.
- TX: MISO holds bit k for the cycle after edge eF+1+k, for k = 0..DATA_WIDTH-1. The edge after the LSB cycle drives MISO=0 and goes to CHK_CMD, or to IDLE if SS_n=1. MOSI is ignored in TX.
- MISO=0 in every state except TX, and on the READ_WAIT→TX edge.
- SS_n=1 sampled in any non-IDLE state: go to IDLE on that edge. The partial frame is discarded (no RAM write, no pointer change), and MISO ← 0.
- Simultaneous SS_n rise and eF: SS_n wins and the command is not executed.
- rst has priority over everything, including mid-frame and mid-TX. Pointers return to 0.
- Write and read pointers are independent. Reading without a prior 10 uses rd_ptr=0.
- RAM: single port, synchronous write and synchronous read. A write and a read never occur in the same cycle, by FSM construction.

Decomposition:
- Shared package spi_ram_pkg holds:
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - state encoding constants;
  - a function computing P.
- One sub-module: spr_param (DATA_WIDTH, ADDR_WIDTH, MEM_DEPTH) with ports clk, we, addr, din, dout, and registered dout. The FSM, shifters and pointers live in the top.

Test Plan:
- Defaults. Frames 00_0x05, 01_0xA5, 01_0x3C in one SS_n burst → mem[5]=0xA5, mem[6]=0x3C, wr_ptr=7. busy=1 throughout and falls one edge after SS_n rises.
- Frames 10_0x05 then 11_0x00, 11_0x00 in one burst → MISO 0xA5 then 0x3C, MSB first. The first bit appears after edge eF+1, and rd_ptr ends at 7.
- Wrap: 00_0xFF, 01_0x11, 01_0x22 → mem[255]=0x11, mem[0]=0x22.
- MEM_DEPTH=200. 00_0xC8 → err=1 and wr_ptr unchanged. A following 01_0x77 writes at the old pointer; err stays 1 until rst.
- Abort: raise SS_n after 6 bits of 01_0x99 → no write, state IDLE. Raise SS_n during TX bit 3 → MISO=0 on the next edge, and rd_ptr is already incremented.
- Assert rst mid-RX → all outputs and pointers are 0 on the next edge. The next frame decodes normally.

Source files
------------

// File: rtl/spi_ram_slave_param_pkg.sv
// Shared definitions for the parametrised SPI RAM slave: command codes,
// FSM state encoding and the payload-width helper.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_RX        = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_TX        = 3'd4
  } state_e;

  // Payload length is wide enough to carry either an address or a data word.
  function automatic int calc_payload_w(input int addr_w, input int data_w);
    return (addr_w > data_w) ? addr_w : data_w;
  endfunction

endpackage

// File: rtl/spi_ram_slave_param_if.sv
// SPI pin bundle between a master (host/bench) and the RAM slave.
interface spi_ram_slave_param_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic err;

  modport master (output SS_n, output MOSI, input MISO, input busy, input err);
  modport slave  (input SS_n, input MOSI, output MISO, output busy, output err);
endinterface

// File: rtl/spi_ram_slave_param_spr.sv
// Single-port RAM with synchronous write and registered read data.
module spr_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
    else    dout        <= r_mem[addr];
  end

endmodule

// File: rtl/spi_ram_slave_param.sv
// SPI slave decoding 2-bit command frames into RAM pointer/data accesses,
// with auto-increment, SS_n bursts and a sticky out-of-range flag.
module spi_ram_slave_param
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input logic                  clk,
  input logic                  rst,
  spi_ram_slave_param_if.slave spi
);

  localparam int P       = calc_payload_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int FRAME_W = P + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_e                  r_state, w_state_nxt;
  logic [FRAME_W-2:0]      r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_tx;
  logic                    r_miso, r_err;

  logic [FRAME_W-1:0]      w_frame;
  logic [1:0]              w_cmd;
  logic [ADDR_WIDTH-1:0]   w_addr, w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_data, w_dout;
  logic                    w_last_bit, w_last_tx, w_addr_bad, w_exec, w_we;

  function automatic logic [ADDR_WIDTH-1:0] ptr_adv(input logic [ADDR_WIDTH-1:0] p);
    if (AUTO_INC == 0)     return p;
    if (p == LAST_ADDR)    return '0;
    return p + 1'b1;
  endfunction

  assign w_frame    = {r_shift, spi.MOSI};
  assign w_cmd      = w_frame[FRAME_W-1 -: 2];
  assign w_addr     = w_frame[ADDR_WIDTH-1:0];
  assign w_data     = w_frame[DATA_WIDTH-1:0];
  assign w_last_bit = (r_cnt == CNT_W'(FRAME_W - 1));
  assign w_last_tx  = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_addr_bad = ({1'b0, w_addr} >= DEPTH_X);
  assign w_we       = w_exec && (w_cmd == CMD_WR_DATA);
  // Only data writes use the write pointer; every other cycle prefetches at rd_ptr.
  assign w_ram_addr = w_we ? r_wr_ptr : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exec      = 1'b0;
    case (r_state)
      ST_IDLE:      if (!spi.SS_n) w_state_nxt = ST_CHK_CMD;
      ST_CHK_CMD:   w_state_nxt = spi.SS_n ? ST_IDLE : ST_RX;
      ST_RX: begin
        if (spi.SS_n) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_bit) begin
          w_exec      = 1'b1;
          w_state_nxt = (w_cmd == CMD_RD_DATA) ? ST_READ_WAIT : ST_CHK_CMD;
        end
      end
      ST_READ_WAIT: w_state_nxt = spi.SS_n ? ST_IDLE : ST_TX;
      ST_TX: begin
        if (spi.SS_n)       w_state_nxt = ST_IDLE;
        else if (w_last_tx) w_state_nxt = ST_CHK_CMD;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_miso   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_miso <= 1'b0;
      case (r_state)
        ST_CHK_CMD: if (!spi.SS_n) begin
          r_shift <= {r_shift[FRAME_W-3:0], spi.MOSI};
          r_cnt   <= CNT_W'(1);
        end
        ST_RX: begin
          if (!spi.SS_n && !w_last_bit) begin
            r_shift <= {r_shift[FRAME_W-3:0], spi.MOSI};
            r_cnt   <= r_cnt + 1'b1;
          end
          if (w_exec) begin
            case (w_cmd)
              CMD_WR_ADDR: if (w_addr_bad) r_err <= 1'b1; else r_wr_ptr <= w_addr;
              CMD_WR_DATA: r_wr_ptr <= ptr_adv(r_wr_ptr);
              CMD_RD_ADDR: if (w_addr_bad) r_err <= 1'b1; else r_rd_ptr <= w_addr;
              default: ;
            endcase
          end
        end
        ST_READ_WAIT: if (!spi.SS_n) begin
          r_miso   <= w_dout[DATA_WIDTH-1];
          r_cnt    <= '0;
          r_rd_ptr <= ptr_adv(r_rd_ptr);
        end
        ST_TX: if (!spi.SS_n && !w_last_tx) begin
          r_miso <= r_tx[DATA_WIDTH-2];
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transmit shifter: loaded from the prefetched RAM word, then shifted MSB-first.
  always_ff @(posedge clk) begin
    if (r_state == ST_READ_WAIT) r_tx <= w_dout;
    else if (r_state == ST_TX)   r_tx <= r_tx << 1;
  end

  spr_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .addr (w_ram_addr),
    .din  (w_data),
    .dout (w_dout)
  );

  assign spi.MISO = r_miso;
  assign spi.busy = (r_state != ST_IDLE);
  assign spi.err  = r_err;

endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Bench for spi_ram_slave_param: a default instance and a MEM_DEPTH=200 instance,
// driven as an SPI master with read data checked through an expected-value queue.
module tb_spi_ram_slave_param;

  localparam int F = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ss_n [2];
  logic mosi [2];
  logic miso_w [2];
  logic busy_w [2];
  logic err_w [2];
  logic busy_drop [2];

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  spi_ram_slave_param_if ifa ();
  spi_ram_slave_param_if ifb ();

  assign ifa.SS_n = ss_n[0];
  assign ifa.MOSI = mosi[0];
  assign ifb.SS_n = ss_n[1];
  assign ifb.MOSI = mosi[1];
  assign miso_w[0] = ifa.MISO;
  assign busy_w[0] = ifa.busy;
  assign err_w[0]  = ifa.err;
  assign miso_w[1] = ifb.MISO;
  assign busy_w[1] = ifb.busy;
  assign err_w[1]  = ifb.err;

  spi_ram_slave_param dut0 (.clk(clk), .rst(rst), .spi(ifa));
  spi_ram_slave_param #(.MEM_DEPTH(200)) dut1 (.clk(clk), .rst(rst), .spi(ifb));

  task automatic start(input int s);
    @(negedge clk);
    ss_n[s] = 1'b0;
    mosi[s] = 1'b0;
    busy_drop[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [1:0] cmd, input logic [7:0] pl, input int nbits = F);
    logic [F-1:0] fr;
    fr = {cmd, pl};
    for (int i = F - 1; i >= F - nbits; i--) begin
      @(negedge clk);
      if (busy_w[s] !== 1'b1) busy_drop[s] = 1'b1;
      mosi[s] = fr[i];
    end
  endtask

  task automatic stop(input int s);
    @(negedge clk);
    ss_n[s] = 1'b1;
    mosi[s] = 1'b0;
  endtask

  task automatic read_out(input int s, input int n, output logic [7:0] v, output logic wait_miso);
    v = '0;
    @(negedge clk);
    wait_miso = miso_w[s];
    mosi[s] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v = {v[6:0], miso_w[s]};
    end
  endtask

  task automatic test_reset();
    ss_n[0] = 1'b1; ss_n[1] = 1'b1; mosi[0] = 1'b0; mosi[1] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++; if ({miso_w[s], busy_w[s], err_w[s]} !== 3'b000)
        $display("FAIL reset_outputs dut%0d got miso/busy/err=%b expected 000", s, {miso_w[s], busy_w[s], err_w[s]}); else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_burst();
    start(0);
    send(0, 2'b00, 8'h05);
    send(0, 2'b01, 8'hA5);
    send(0, 2'b01, 8'h3C);
    stop(0);
    n_checks++; if (busy_w[0] !== 1'b1 || busy_drop[0] !== 1'b0)
      $display("FAIL busy_during_burst got busy=%b drop=%b expected 1/0", busy_w[0], busy_drop[0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0)
      $display("FAIL busy_after_ss_rise got %b expected 0", busy_w[0]); else n_pass++;
    start(0);
    send(0, 2'b01, 8'h5A);
    stop(0);
  endtask

  task automatic test_read_burst();
    logic [7:0] got, exp;
    logic wm;
    start(0);
    send(0, 2'b10, 8'h05);
    for (int i = 0; i < 3; i++) begin
      send(0, 2'b11, 8'h00);
      exp_q.push_back(i == 0 ? 8'hA5 : (i == 1 ? 8'h3C : 8'h5A));
      read_out(0, 8, got, wm);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp)
        $display("FAIL read_burst_%0d got %h expected %h", i, got, exp); else n_pass++;
      n_checks++; if (wm !== 1'b0)
        $display("FAIL miso_read_wait_%0d got %b expected 0", i, wm); else n_pass++;
    end
    stop(0);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] got, exp;
    logic wm;
    start(0);
    send(0, 2'b00, 8'hFF);
    send(0, 2'b01, 8'h11);
    send(0, 2'b01, 8'h22);
    stop(0);
    start(0);
    send(0, 2'b10, 8'hFF);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    for (int i = 0; i < 2; i++) begin
      send(0, 2'b11, 8'h00);
      read_out(0, 8, got, wm);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp)
        $display("FAIL wrap_read_%0d got %h expected %h", i, got, exp); else n_pass++;
    end
    stop(0);
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [7:0] got, exp;
    logic wm;
    start(1);
    send(1, 2'b00, 8'h10);
    @(negedge clk);
    n_checks++; if (err_w[1] !== 1'b0)
      $display("FAIL err_valid_addr got %b expected 0", err_w[1]); else n_pass++;
    ss_n[1] = 1'b1;
    start(1);
    send(1, 2'b00, 8'hC8);
    stop(1);
    @(negedge clk);
    n_checks++; if (err_w[1] !== 1'b1)
      $display("FAIL err_set got %b expected 1", err_w[1]); else n_pass++;
    start(1);
    send(1, 2'b01, 8'h77);
    send(1, 2'b10, 8'h10);
    send(1, 2'b10, 8'hC8);
    send(1, 2'b11, 8'h00);
    exp_q.push_back(8'h77);
    read_out(1, 8, got, wm);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp)
      $display("FAIL err_ptr_unchanged got %h expected %h", got, exp); else n_pass++;
    stop(1);
    @(negedge clk);
    n_checks++; if (err_w[1] !== 1'b1)
      $display("FAIL err_sticky got %b expected 1", err_w[1]); else n_pass++;
    n_checks++; if (err_w[0] !== 1'b0)
      $display("FAIL err_default_dut got %b expected 0", err_w[0]); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] got, exp;
    logic wm;
    start(0);
    send(0, 2'b00, 8'h20);
    send(0, 2'b01, 8'h55);
    send(0, 2'b01, 8'h66);
    stop(0);
    start(0);
    send(0, 2'b01, 8'h99, 6);
    stop(0);
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0)
      $display("FAIL abort_rx_idle got busy=%b expected 0", busy_w[0]); else n_pass++;
    start(0);
    send(0, 2'b01, 8'h77);
    send(0, 2'b10, 8'h21);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 2; i++) begin
      send(0, 2'b11, 8'h00);
      read_out(0, 8, got, wm);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp)
        $display("FAIL abort_rx_read_%0d got %h expected %h", i, got, exp); else n_pass++;
    end
    stop(0);
    start(0);
    send(0, 2'b10, 8'h20);
    send(0, 2'b11, 8'h00);
    read_out(0, 4, got, wm);
    ss_n[0] = 1'b1;
    n_checks++; if (got[3:0] !== 4'b0101)
      $display("FAIL abort_tx_bits got %b expected 0101", got[3:0]); else n_pass++;
    @(negedge clk);
    n_checks++; if ({miso_w[0], busy_w[0]} !== 2'b00)
      $display("FAIL abort_tx_miso got miso/busy=%b expected 00", {miso_w[0], busy_w[0]}); else n_pass++;
    start(0);
    send(0, 2'b11, 8'h00);
    exp_q.push_back(8'h66);
    read_out(0, 8, got, wm);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp)
      $display("FAIL abort_tx_rdptr got %h expected %h", got, exp); else n_pass++;
    stop(0);
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [7:0] got, exp;
    logic wm;
    start(0);
    send(0, 2'b00, 8'h40, 5);
    @(negedge clk);
    rst = 1'b1;
    ss_n[0] = 1'b1;
    ss_n[1] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++; if ({miso_w[s], busy_w[s], err_w[s]} !== 3'b000)
        $display("FAIL rst_mid_outputs dut%0d got %b expected 000", s, {miso_w[s], busy_w[s], err_w[s]}); else n_pass++;
    end
    rst = 1'b0;
    start(0);
    send(0, 2'b01, 8'hEE);
    send(0, 2'b11, 8'h00);
    exp_q.push_back(8'hEE);
    read_out(0, 8, got, wm);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp)
      $display("FAIL rst_mid_ptrs got %h expected %h", got, exp); else n_pass++;
    stop(0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_err();
    test_abort();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
